// File: rtl/mux0_uart_if.sv
// CPU6 bus-side signals of the MUX 0 serial port.
// The master modport is the CPU or bus glue; the slave modport is the UART.
interface mux0_uart_if;
  logic [18:0] address;
  logic        write_en;
  logic        read_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        select;

  modport master (
    output address, write_en, read_en, data_in,
    input  data_out, select
  );

  modport slave (
    input  address, write_en, read_en, data_in,
    output data_out, select
  );
endinterface

// File: rtl/mux0_uart.sv
// MUX 0 serial port: status register at 0x3F200 and data register at 0x3F201.
// Writes are queued in a small TX FIFO and sent as 8N1 frames; received 8N1 frames land in rx_buf.
module mux0_uart #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TX_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  mux0_uart_if.slave bus,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned PtrW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(TX_DEPTH + 1);
  localparam int unsigned DivW = $clog2(CLKS_PER_BIT);

  localparam logic [18:0]     StatusAddr = 19'h3F200;
  localparam logic [18:0]     DataAddr   = 19'h3F201;
  localparam logic [DivW-1:0] BitLast    = DivW'(CLKS_PER_BIT - 1);
  localparam logic [DivW-1:0] HalfLast   = DivW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullCount  = CntW'(TX_DEPTH);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Bus decode
  logic sel_status, sel_data;
  logic rd_status, rd_data;

  assign sel_status = (bus.address == StatusAddr);
  assign sel_data   = (bus.address == DataAddr);
  assign bus.select = sel_status | sel_data;
  assign rd_status  = bus.read_en & sel_status;
  assign rd_data    = bus.read_en & sel_data;

  // TX FIFO
  logic [7:0]      fifo_q [TX_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_empty, txr;
  logic            fifo_push, tx_pop;

  assign fifo_empty = (count_q == '0);
  assign txr        = (count_q != FullCount);
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign fifo_push  = bus.write_en & sel_data & (txr | tx_pop);

  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_q[wr_ptr_q] <= bus.data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (tx_pop)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({fifo_push, tx_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmitter
  tx_state_e       tx_state_q;
  logic [DivW-1:0] tx_div_q;
  logic [2:0]      tx_bit_q;
  logic [7:0]      tx_sh_q;
  logic            txd_q;
  logic            tx_div_end;

  assign tx_div_end = (tx_div_q == BitLast);
  assign tx_pop     = !fifo_empty &&
                      ((tx_state_q == TxIdle) || (tx_state_q == TxStop && tx_div_end));
  assign txd        = txd_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_div_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          if (!fifo_empty) begin
            tx_state_q <= TxStart;
            tx_sh_q    <= fifo_q[rd_ptr_q];
            tx_div_q   <= '0;
            txd_q      <= 1'b0;
          end
        end
        TxStart: begin
          if (tx_div_end) begin
            tx_state_q <= TxData;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= tx_sh_q[0];
          end else begin
            tx_div_q <= tx_div_q + DivW'(1);
          end
        end
        TxData: begin
          if (tx_div_end) begin
            tx_div_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TxStop;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              txd_q    <= tx_sh_q[1];
            end
          end else begin
            tx_div_q <= tx_div_q + DivW'(1);
          end
        end
        TxStop: begin
          if (tx_div_end) begin
            tx_div_q <= '0;
            // Back-to-back frames: no idle gap when more data is queued.
            if (!fifo_empty) begin
              tx_state_q <= TxStart;
              tx_sh_q    <= fifo_q[rd_ptr_q];
              txd_q      <= 1'b0;
            end else begin
              tx_state_q <= TxIdle;
            end
          end else begin
            tx_div_q <= tx_div_q + DivW'(1);
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  // Receiver
  rx_state_e       rx_state_q;
  logic [DivW-1:0] rx_div_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;
  logic [7:0]      rx_buf_q;
  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic            rxf_q, fe_q, ovr_q;
  logic            rx_div_end;

  assign rx_div_end = (rx_div_q == BitLast);

  // Clears come first so a same-cycle set event overrides them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_buf_q   <= '0;
      rxf_q      <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (rd_data) rxf_q <= 1'b0;
      if (rd_status) begin
        fe_q  <= 1'b0;
        ovr_q <= 1'b0;
      end
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= RxStart;
            rx_div_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_div_q == HalfLast) begin
            rx_div_q <= '0;
            if (rx_s2_q) begin
              rx_state_q <= RxIdle;
            end else begin
              rx_state_q <= RxData;
              rx_bit_q   <= '0;
            end
          end else begin
            rx_div_q <= rx_div_q + DivW'(1);
          end
        end
        RxData: begin
          if (rx_div_end) begin
            rx_div_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RxStop;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_div_q <= rx_div_q + DivW'(1);
          end
        end
        RxStop: begin
          if (rx_div_end) begin
            rx_div_q   <= '0;
            rx_state_q <= RxIdle;
            if (!rxf_q || rd_data) begin
              rx_buf_q <= rx_sh_q;
              rxf_q    <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
            if (!rx_s2_q) fe_q <= 1'b1;
          end else begin
            rx_div_q <= rx_div_q + DivW'(1);
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // Read data
  logic       txb;
  logic [7:0] status;

  assign txb    = (tx_state_q != TxIdle) || !fifo_empty;
  assign status = {2'b00, ovr_q, fe_q, txb, 1'b0, txr, rxf_q};

  always_comb begin
    bus.data_out = 8'h00;
    if (sel_status) begin
      bus.data_out = status;
    end else if (sel_data) begin
      bus.data_out = rx_buf_q;
    end
  end

endmodule

// File: tb/tb_mux0_uart.sv
// Directed bench for mux0_uart: TX frames are decoded by a monitor and scored against a queue
// of expected bytes; RX frames are driven bit by bit and scored the same way.
module tb_mux0_uart;

  localparam int unsigned CPB    = 16;
  localparam logic [18:0] AStat  = 19'h3F200;
  localparam logic [18:0] AData  = 19'h3F201;
  localparam logic [18:0] AOther = 19'h3F100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
  logic rxd = 1'b1;

  mux0_uart_if bus ();

  mux0_uart #(
    .CLKS_PER_BIT(CPB),
    .TX_DEPTH    (4)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus),
    .txd  (txd),
    .rxd  (rxd)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  tx_exp_q[$];
  logic [7:0]  rx_exp_q[$];
  logic [7:0]  got_q[$];
  int unsigned got_cyc[$];
  logic        got_stop[$];
  bit          mon_en = 1'b1;

  // TX monitor: decode each frame at mid-bit and record its start cycle.
  logic [7:0]  mon_b;
  int unsigned mon_c0;
  logic        mon_stop;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_en && !rst && txd === 1'b0) begin
        mon_c0 = cyc;
        repeat (CPB / 2) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(posedge clk); #1; end
          mon_b[i] = txd;
        end
        repeat (CPB) begin @(posedge clk); #1; end
        mon_stop = txd;
        got_q.push_back(mon_b);
        got_cyc.push_back(mon_c0);
        got_stop.push_back(mon_stop);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
    bus.address  = a;
    bus.data_in  = d;
    bus.write_en = 1'b1;
    tick();
    bus.write_en = 1'b0;
  endtask

  task automatic read_strobe(input logic [18:0] a);
    bus.address = a;
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [7:0] e);
    bus.address = AStat;
    #1;
    chk(tag, 32'(bus.data_out), 32'(e));
  endtask

  task automatic chk_rx_buf(input string tag);
    bus.address = AData;
    #1;
    if (rx_exp_q.size() > 0) chk(tag, 32'(bus.data_out), 32'(rx_exp_q.pop_front()));
    else chk({tag, "_sb"}, 32'(rx_exp_q.size()), 32'd1);
  endtask

  task automatic wait_frames(input int n, input int lim);
    for (int i = 0; i < lim && got_q.size() < n; i++) tick();
    chk("tx_frame_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic score_frames(input int n);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() > 0 && tx_exp_q.size() > 0) begin
        chk("tx_byte", 32'(got_q.pop_front()), 32'(tx_exp_q.pop_front()));
        chk("tx_stop", 32'(got_stop.pop_front()), 32'd1);
        void'(got_cyc.pop_front());
      end
    end
  endtask

  task automatic wait_txb_clear(input int lim);
    bus.address = AStat;
    #1;
    for (int i = 0; i < lim && bus.data_out[3] !== 1'b0; i++) tick();
    chk("txb_clear", 32'(bus.data_out[3]), 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      ticks(CPB);
    end
    rxd = stop;
    ticks(CPB);
    rxd = 1'b1;
    ticks(CPB);
  endtask

  logic [7:0]  hello [6] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h72};
  int unsigned c_first;
  int          low_cnt;

  initial begin
    bus.address  = AOther;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.data_in  = 8'h00;

    // Reset state and decode
    ticks(3);
    rst = 1'b0;
    tick();
    chk_status("reset_status", 8'h02);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("sel_status", 32'(bus.select), 32'd1);
    bus.address = AData;
    #1;
    chk("sel_data", 32'(bus.select), 32'd1);
    bus.address = AOther;
    #1;
    chk("sel_other", 32'(bus.select), 32'd0);
    chk("dout_other", 32'(bus.data_out), 32'd0);

    // Single frame 0x48
    bus_write(AData, 8'h48);
    tx_exp_q.push_back(8'h48);
    chk_status("txb_queued", 8'h0A);
    ticks(50);
    chk_status("txb_mid_frame", 8'h0A);
    wait_frames(1, 400);
    c_first = (got_cyc.size() > 0) ? got_cyc[0] : 0;
    score_frames(1);
    wait_txb_clear(300);
    chk("frame_len", cyc - c_first, 32'd160);
    chk_status("tx_done", 8'h02);

    // Back-to-back "hello" plus one dropped write
    for (int i = 0; i < 5; i++) begin
      bus_write(AData, hello[i]);
      tx_exp_q.push_back(hello[i]);
    end
    chk_status("txr_full", 8'h08);
    bus_write(AData, hello[5]);
    chk_status("txr_after_drop", 8'h08);
    wait_frames(5, 1000);
    if (got_cyc.size() >= 5) begin
      c_first = got_cyc[0];
      for (int i = 1; i < 5; i++) chk("tx_gap", got_cyc[i] - got_cyc[i-1], 32'd160);
    end
    score_frames(5);
    wait_txb_clear(300);
    chk("hello_len", cyc - c_first, 32'd800);
    ticks(200);
    chk("sixth_dropped", 32'(got_q.size()), 32'd0);

    // RX single byte
    rx_exp_q.push_back(8'h0D);
    send_rx(8'h0D, 1'b1);
    chk_status("rx_status", 8'h03);
    chk_rx_buf("rx_buf_0d");
    read_strobe(AData);
    chk_status("rx_cleared", 8'h02);

    // RX overrun: second byte is lost
    rx_exp_q.push_back(8'h41);
    send_rx(8'h41, 1'b1);
    send_rx(8'h42, 1'b1);
    chk_status("ovr_status", 8'h23);
    chk_rx_buf("rx_buf_ovr");
    read_strobe(AStat);
    chk_status("ovr_cleared", 8'h03);
    read_strobe(AData);
    chk_status("rxf_cleared", 8'h02);

    // Framing error, then a short glitch
    rx_exp_q.push_back(8'h55);
    send_rx(8'h55, 1'b0);
    chk_status("fe_status", 8'h13);
    chk_rx_buf("rx_buf_fe");
    read_strobe(AData);
    chk_status("fe_sticky", 8'h12);
    rxd = 1'b0;
    ticks(4);
    rxd = 1'b1;
    ticks(3 * CPB);
    chk_status("glitch_rejected", 8'h12);
    read_strobe(AStat);
    chk_status("fe_cleared", 8'h02);

    // Reset mid-transmit
    mon_en = 1'b0;
    bus_write(AData, 8'h5A);
    bus_write(AData, 8'hA5);
    ticks(40);
    chk_status("busy_before_reset", 8'h0A);
    rst = 1'b1;
    #1;
    chk("reset_txd_now", 32'(txd), 32'd1);
    chk_status("reset_status_now", 8'h02);
    ticks(2);
    rst = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txd !== 1'b1) low_cnt++;
    end
    chk("post_reset_idle", 32'(low_cnt), 32'd0);
    chk_status("post_reset_status", 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
